mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
Shares one unified instruction/data memory port between the fetch stage and the memory stage of the pipelined core. Arbitrates between the two requesters and sequences each variable-latency access through a small FSM. Returns read data and completion pulses to the requesters, and drives per-stage stall signals into the pipeline hazard logic. Data accesses win by default; a starvation limit guarantees that fetch still makes forward progress.

Parameters:
WORD_SIZE, 32, data width in bits; must be a multiple of 8.
ADDR_WIDTH, 32, byte-address width.
STARVE_LIMIT, 4, number of consecutive data grants given while fetch waits before fetch is forced to win; must be ≥1.

Ports:
clk  in  1  single clock
reset_n  in  1  asynchronous active-low reset
if_req  in  1  fetch needs an access (level)
if_addr  in  ADDR_WIDTH  fetch address
if_gnt  out  1  one-cycle pulse: fetch access accepted
if_rvalid  out  1  one-cycle pulse: fetch access complete, if_rdata valid
if_rdata  out  WORD_SIZE  fetch read data
dm_req  in  1  load/store needs an access (level)
dm_we  in  1  1 = store
dm_addr  in  ADDR_WIDTH  data address
dm_wdata  in  WORD_SIZE  store data
dm_be  in  WORD_SIZE/8  store byte enables
dm_gnt  out  1  one-cycle pulse: data access accepted
dm_rvalid  out  1  one-cycle pulse: data access complete (loads and stores)
dm_rdata  out  WORD_SIZE  load data
mem_req  out  1  memory access in flight
mem_we, mem_addr, mem_wdata, mem_be  out  1/ADDR_WIDTH/WORD_SIZE/WORD_SIZE/8  registered access fields
mem_ack  in  1  one-cycle pulse: access complete; mem_rdata valid in the same cycle
mem_rdata  in  WORD_SIZE  memory read data
stall_fetch  out  1  fetch stage must hold
stall_mem  out  1  memory stage must hold

Behaviour:
- Clock and reset: one clock (clk); reset_n is asynchronous and active-low.
- Reset values: state=ARB_IDLE, starve_cnt=0. mem_req, mem_we, mem_addr, mem_wdata and mem_be are all 0. All gnt and rvalid outputs are 0.
- FSM states: ARB_IDLE, ARB_FETCH, ARB_DATA.
- Arbitration point: the FSM is in ARB_IDLE, or the FSM is in a busy state and mem_ack=1.
- Arbitration decision at an arbitration point:
  - Only dm_req eligible → grant data.
  - Only if_req eligible → grant fetch.
  - Both eligible → grant data, unless starve_cnt==STARVE_LIMIT, in which case grant fetch.
- Eligibility: a requester is eligible only if its req=1 and it is not the requester whose access completes in this same cycle. A requester that just completed may re-request starting on the next cycle.
- On a grant (same cycle, combinational):
  - The matching gnt output is high.
  - The address, we, wdata and be fields are captured into the mem_* registers on the next edge.
  - mem_req=1 from the next cycle onward.
  - The FSM moves to ARB_FETCH or ARB_DATA.
  - Fetch grants drive mem_we=0 and mem_be=0.
- Fetch-request fields must stay stable while req=1 and no gnt has been seen; the arbiter samples them only in the gnt cycle.
- In ARB_X with mem_ack=1:
  - X_rvalid=1 in that cycle; X_rdata = mem_rdata (combinational pass-through).
  - If no new grant is made, the FSM returns to ARB_IDLE and mem_req=0 on the next edge.
  - If a new grant is made in the ack cycle, mem_req stays 1 and the new fields are loaded. This gives back-to-back accesses with no idle bubble.
- if_rdata and dm_rdata hold their last value when rvalid=0. The value is don't-care for the bench; it is checked only when rvalid=1.
- Access latency: the minimum is 2 cycles from req to rvalid (grant cycle, then a memory ack in the next cycle). There is no upper bound; the FSM waits on mem_ack indefinitely.
- mem_ack received while in ARB_IDLE is ignored: no rvalid and no state change.
- starve_cnt behaviour:
  - Increments on each data grant made while if_req=1.
  - Saturates at STARVE_LIMIT.
  - Clears to 0 on any fetch grant.
  - Unchanged otherwise.
- Stall outputs: stall_fetch = if_req & ~if_rvalid; stall_mem = dm_req & ~dm_rvalid. Both are combinational.
- Reset asserted mid-access:
  - The FSM returns to ARB_IDLE, mem_req drops asynchronously, and starve_cnt=0.
  - The memory treats a dropped mem_req as an abort.
  - Any mem_ack arriving after reset release is ignored by the ARB_IDLE rule.
- Stores: dm_rvalid pulses on mem_ack; dm_rdata is don't-care for stores.

Decomposition:
- Add to the HighLevelControl package:
  - typedef enum memArbState {ARB_IDLE, ARB_FETCH, ARB_DATA}.
  - typedef enum memRequester {REQ_NONE, REQ_FETCH, REQ_DATA}, used for the grant-select signal.
- One sub-module, starvation_counter. It is parameterised by STARVE_LIMIT, takes inc and clr inputs, and provides a count output and an at_limit output.

Test Plan:
- Fetch only: if_req=1, if_addr=0x100; mem_ack arrives 1 cycle after mem_req → if_gnt in cycle 0, mem_req/mem_addr=0x100 in cycle 1, if_rvalid with if_rdata=mem_rdata=0xDEADBEEF in cycle 1, stall_fetch low only in that cycle.
- Simultaneous requests: if_req=dm_req=1, dm_we=1, dm_addr=0x200, dm_be=0xF → data granted first with mem_we=1; fetch granted in the dm ack cycle; second mem_req has mem_addr=if_addr and mem_we=0, with no idle cycle.
- Starvation: STARVE_LIMIT=4, if_req held high, dm_req re-requested continuously → exactly 4 data grants, then fetch wins the 5th arbitration; starve_cnt reads 0 afterward.
- Variable latency: mem_ack delayed 7 cycles → mem_* fields stable for all 7 cycles, stall_mem high for the whole wait, dm_rvalid a single pulse.
- Stray ack and reset: mem_ack pulse in ARB_IDLE → no rvalid and no state change. reset_n low mid-ARB_DATA → mem_req=0 immediately, state=ARB_IDLE, starve_cnt=0; an ack after release is ignored.

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the unified memory-port arbiter: FSM states, grant select and counter sizing.
package mem_port_arbiter_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_FETCH = 2'd1,
        ARB_DATA  = 2'd2
    } memArbState;

    typedef enum logic [1:0] {
        REQ_NONE  = 2'd0,
        REQ_FETCH = 2'd1,
        REQ_DATA  = 2'd2
    } memRequester;

    localparam int unsigned DEF_WORD_SIZE    = 32;
    localparam int unsigned DEF_ADDR_WIDTH   = 32;
    localparam int unsigned DEF_STARVE_LIMIT = 4;

    function automatic int unsigned starve_cnt_width(input int unsigned limit);
        return (limit < 1) ? 1 : $clog2(limit + 1);
    endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Requester, memory and stall signals of the shared memory port.
interface mem_port_arbiter_if #(
    parameter int unsigned WORD_SIZE  = 32,
    parameter int unsigned ADDR_WIDTH = 32
);
    logic                    if_req;
    logic [ADDR_WIDTH-1:0]   if_addr;
    logic                    if_gnt;
    logic                    if_rvalid;
    logic [WORD_SIZE-1:0]    if_rdata;

    logic                    dm_req;
    logic                    dm_we;
    logic [ADDR_WIDTH-1:0]   dm_addr;
    logic [WORD_SIZE-1:0]    dm_wdata;
    logic [WORD_SIZE/8-1:0]  dm_be;
    logic                    dm_gnt;
    logic                    dm_rvalid;
    logic [WORD_SIZE-1:0]    dm_rdata;

    logic                    mem_req;
    logic                    mem_we;
    logic [ADDR_WIDTH-1:0]   mem_addr;
    logic [WORD_SIZE-1:0]    mem_wdata;
    logic [WORD_SIZE/8-1:0]  mem_be;
    logic                    mem_ack;
    logic [WORD_SIZE-1:0]    mem_rdata;

    logic                    stall_fetch;
    logic                    stall_mem;

    // Arbiter side.
    modport slave (
        input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, dm_be, mem_ack, mem_rdata,
        output if_gnt, if_rvalid, if_rdata, dm_gnt, dm_rvalid, dm_rdata,
        output mem_req, mem_we, mem_addr, mem_wdata, mem_be, stall_fetch, stall_mem
    );

    // Pipeline plus memory side.
    modport master (
        output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, dm_be, mem_ack, mem_rdata,
        input  if_gnt, if_rvalid, if_rdata, dm_gnt, dm_rvalid, dm_rdata,
        input  mem_req, mem_we, mem_addr, mem_wdata, mem_be, stall_fetch, stall_mem
    );
endinterface

// File: rtl/mem_port_arbiter_starvation_counter.sv
// Counts data grants made while fetch waits; saturates at STARVE_LIMIT, clear has priority.
module starvation_counter
    import mem_port_arbiter_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = DEF_STARVE_LIMIT,
    localparam int unsigned CW = starve_cnt_width(STARVE_LIMIT)
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          inc_i,
    input  logic          clr_i,
    output logic [CW-1:0] count_o,
    output logic          at_limit_o
);

    logic [CW-1:0] count_q, count_d;

    assign at_limit_o = (count_q == CW'(STARVE_LIMIT));
    assign count_o    = count_q;

    always_comb begin
        count_d = count_q;
        if (clr_i)
            count_d = '0;
        else if (inc_i && !at_limit_o)
            count_d = count_q + CW'(1);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) count_q <= '0;
        else          count_q <= count_d;
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates fetch and data requesters onto one variable-latency memory port.
//   state     | meaning
//   ARB_IDLE  | no access in flight, arbitrate every cycle
//   ARB_FETCH | fetch access in flight, waiting for mem_ack
//   ARB_DATA  | data access in flight, waiting for mem_ack
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int unsigned WORD_SIZE    = DEF_WORD_SIZE,
    parameter int unsigned ADDR_WIDTH   = DEF_ADDR_WIDTH,
    parameter int unsigned STARVE_LIMIT = DEF_STARVE_LIMIT
) (
    input logic               clk,
    input logic               reset_n,
    mem_port_arbiter_if.slave bus
);

    localparam int unsigned BW = WORD_SIZE / 8;
    localparam int unsigned CW = starve_cnt_width(STARVE_LIMIT);

    memArbState              state_q, state_d;
    memRequester             sel;
    logic                    mem_req_q, mem_req_d;
    logic                    mem_we_q, mem_we_d;
    logic [ADDR_WIDTH-1:0]   mem_addr_q, mem_addr_d;
    logic [WORD_SIZE-1:0]    mem_wdata_q, mem_wdata_d;
    logic [BW-1:0]           mem_be_q, mem_be_d;
    logic [WORD_SIZE-1:0]    if_rdata_q, dm_rdata_q;
    logic                    ack_fetch, ack_data, arb_point, if_elig, dm_elig;
    logic [CW-1:0]           starve_cnt;
    logic                    at_limit;

    assign ack_fetch = (state_q == ARB_FETCH) && bus.mem_ack;
    assign ack_data  = (state_q == ARB_DATA)  && bus.mem_ack;
    assign arb_point = (state_q == ARB_IDLE) || ack_fetch || ack_data;
    // The requester completing this cycle sits out the arbitration in that same cycle.
    assign if_elig   = bus.if_req && !ack_fetch;
    assign dm_elig   = bus.dm_req && !ack_data;

    always_comb begin
        sel         = REQ_NONE;
        state_d     = state_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_be_d    = mem_be_q;
        if (arb_point) begin
            if (dm_elig && !(if_elig && at_limit))
                sel = REQ_DATA;
            else if (if_elig)
                sel = REQ_FETCH;
        end
        case (sel)
            REQ_FETCH: begin
                state_d     = ARB_FETCH;
                mem_req_d   = 1'b1;
                mem_we_d    = 1'b0;
                mem_addr_d  = bus.if_addr;
                mem_wdata_d = '0;
                mem_be_d    = '0;
            end
            REQ_DATA: begin
                state_d     = ARB_DATA;
                mem_req_d   = 1'b1;
                mem_we_d    = bus.dm_we;
                mem_addr_d  = bus.dm_addr;
                mem_wdata_d = bus.dm_wdata;
                mem_be_d    = bus.dm_be;
            end
            default: begin
                if (ack_fetch || ack_data) begin
                    state_d   = ARB_IDLE;
                    mem_req_d = 1'b0;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ARB_IDLE;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_be_q    <= '0;
            if_rdata_q  <= '0;
            dm_rdata_q  <= '0;
        end else begin
            state_q     <= state_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_be_q    <= mem_be_d;
            if (ack_fetch) if_rdata_q <= bus.mem_rdata;
            if (ack_data)  dm_rdata_q <= bus.mem_rdata;
        end
    end

    starvation_counter #(.STARVE_LIMIT(STARVE_LIMIT)) u_starve (
        .clk        (clk),
        .reset_n    (reset_n),
        .inc_i      ((sel == REQ_DATA) && bus.if_req),
        .clr_i      (sel == REQ_FETCH),
        .count_o    (starve_cnt),
        .at_limit_o (at_limit)
    );

    assign bus.if_gnt      = (sel == REQ_FETCH);
    assign bus.dm_gnt      = (sel == REQ_DATA);
    assign bus.if_rvalid   = ack_fetch;
    assign bus.dm_rvalid   = ack_data;
    assign bus.if_rdata    = ack_fetch ? bus.mem_rdata : if_rdata_q;
    assign bus.dm_rdata    = ack_data  ? bus.mem_rdata : dm_rdata_q;
    assign bus.mem_req     = mem_req_q;
    assign bus.mem_we      = mem_we_q;
    assign bus.mem_addr    = mem_addr_q;
    assign bus.mem_wdata   = mem_wdata_q;
    assign bus.mem_be      = mem_be_q;
    assign bus.stall_fetch = bus.if_req & ~ack_fetch;
    assign bus.stall_mem   = bus.dm_req & ~ack_data;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios plus a randomized run against a reference model.
module tb_mem_port_arbiter;
    import mem_port_arbiter_pkg::*;

    localparam int WS    = 32;
    localparam int AW    = 32;
    localparam int LIMIT = 4;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    mem_port_arbiter_if #(.WORD_SIZE(WS), .ADDR_WIDTH(AW)) bus ();

    mem_port_arbiter #(.WORD_SIZE(WS), .ADDR_WIDTH(AW), .STARVE_LIMIT(LIMIT)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: who owns the port, what was last issued, and how long fetch has been passed over.
    int          m_owner;   // 0 none, 1 fetch, 2 data
    int          m_starve;
    logic        m_req, m_we;
    logic [31:0] m_addr, m_wdata;
    logic [3:0]  m_be;

    logic        e_if_gnt, e_dm_gnt, e_if_rv, e_dm_rv, e_stall_f, e_stall_m;
    logic        e_mem_req, e_mem_we;
    logic [31:0] e_rdata, e_mem_addr, e_mem_wdata;
    logic [3:0]  e_mem_be;

    logic        a_if_gnt, a_dm_gnt, a_if_rv, a_dm_rv, a_stall_f, a_stall_m;
    logic        a_mem_req, a_mem_we;
    logic [31:0] a_if_rdata, a_dm_rdata, a_mem_addr, a_mem_wdata;
    logic [3:0]  a_mem_be;

    task automatic model_reset();
        m_owner = 0; m_starve = 0; m_req = 1'b0; m_we = 1'b0;
        m_addr = '0; m_wdata = '0; m_be = '0;
    endtask

    task automatic clear_inputs();
        bus.if_req = 1'b0; bus.if_addr = '0;
        bus.dm_req = 1'b0; bus.dm_we = 1'b0; bus.dm_addr = '0; bus.dm_wdata = '0; bus.dm_be = '0;
        bus.mem_ack = 1'b0; bus.mem_rdata = '0;
    endtask

    task automatic apply_reset();
        reset_n = 1'b0;
        clear_inputs();
        model_reset();
        #13;
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // One clock: sample the DUT mid-cycle, derive expectations from the model, advance the model.
    task automatic step();
        logic ack, if_done, dm_done, if_ok, dm_ok;
        int g;
        @(negedge clk);
        a_if_gnt = bus.if_gnt;   a_dm_gnt = bus.dm_gnt;
        a_if_rv = bus.if_rvalid; a_dm_rv = bus.dm_rvalid;
        a_if_rdata = bus.if_rdata; a_dm_rdata = bus.dm_rdata;
        a_stall_f = bus.stall_fetch; a_stall_m = bus.stall_mem;
        a_mem_req = bus.mem_req; a_mem_we = bus.mem_we; a_mem_addr = bus.mem_addr;
        a_mem_wdata = bus.mem_wdata; a_mem_be = bus.mem_be;

        ack     = bus.mem_ack && (m_owner != 0);
        if_done = ack && (m_owner == 1);
        dm_done = ack && (m_owner == 2);
        if_ok   = bus.if_req && !if_done;
        dm_ok   = bus.dm_req && !dm_done;
        g = 0;
        if (m_owner == 0 || ack) begin
            if (if_ok && dm_ok) g = (m_starve == LIMIT) ? 1 : 2;
            else if (dm_ok)     g = 2;
            else if (if_ok)     g = 1;
        end
        e_if_gnt = (g == 1); e_dm_gnt = (g == 2);
        e_if_rv = if_done;   e_dm_rv = dm_done;
        e_rdata = bus.mem_rdata;
        e_stall_f = bus.if_req && !if_done;
        e_stall_m = bus.dm_req && !dm_done;
        e_mem_req = m_req; e_mem_we = m_we; e_mem_addr = m_addr; e_mem_wdata = m_wdata; e_mem_be = m_be;

        if (g == 2 && bus.if_req && m_starve < LIMIT) m_starve++;
        if (g == 1) m_starve = 0;
        if (g == 1) begin
            m_owner = 1; m_req = 1'b1; m_we = 1'b0; m_addr = bus.if_addr; m_wdata = '0; m_be = '0;
        end else if (g == 2) begin
            m_owner = 2; m_req = 1'b1; m_we = bus.dm_we; m_addr = bus.dm_addr;
            m_wdata = bus.dm_wdata; m_be = bus.dm_be;
        end else if (ack) begin
            m_owner = 0; m_req = 1'b0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        apply_reset();
        step();
        n_cmp++; if (a_mem_req !== 1'b0) begin n_err++; $display("FAIL reset_mem_req got=%b exp=0", a_mem_req); end
        n_cmp++; if (a_mem_addr !== 32'h0) begin n_err++; $display("FAIL reset_mem_addr got=%h exp=0", a_mem_addr); end
        n_cmp++; if ({a_if_gnt, a_dm_gnt, a_if_rv, a_dm_rv} !== 4'b0) begin
            n_err++; $display("FAIL reset_pulses got=%b exp=0000", {a_if_gnt, a_dm_gnt, a_if_rv, a_dm_rv}); end
        n_cmp++; if (dut.state_q !== ARB_IDLE || int'(dut.starve_cnt) !== 0) begin
            n_err++; $display("FAIL reset_state got=%0d/%0d exp=0/0", dut.state_q, dut.starve_cnt); end
    endtask

    task automatic test_fetch_only();
        apply_reset();
        bus.if_req = 1'b1; bus.if_addr = 32'h100;
        step();
        n_cmp++; if (a_if_gnt !== 1'b1 || a_stall_f !== 1'b1) begin
            n_err++; $display("FAIL fetch_gnt got=%b stall=%b exp=1/1", a_if_gnt, a_stall_f); end
        bus.mem_ack = 1'b1; bus.mem_rdata = 32'hDEADBEEF;
        step();
        n_cmp++; if (a_mem_req !== 1'b1 || a_mem_addr !== 32'h100 || a_mem_we !== 1'b0 || a_mem_be !== 4'h0) begin
            n_err++; $display("FAIL fetch_mem got=%b/%h/%b/%h exp=1/100/0/0", a_mem_req, a_mem_addr, a_mem_we, a_mem_be); end
        n_cmp++; if (a_if_rv !== 1'b1 || a_if_rdata !== 32'hDEADBEEF || a_stall_f !== 1'b0) begin
            n_err++; $display("FAIL fetch_rvalid got=%b/%h stall=%b exp=1/deadbeef/0", a_if_rv, a_if_rdata, a_stall_f); end
        n_cmp++; if (a_if_gnt !== 1'b0) begin n_err++; $display("FAIL fetch_no_regrant got=%b exp=0", a_if_gnt); end
        bus.if_req = 1'b0; bus.mem_ack = 1'b0;
        step();
        n_cmp++; if (a_mem_req !== 1'b0 || a_if_rv !== 1'b0) begin
            n_err++; $display("FAIL fetch_idle got=%b/%b exp=0/0", a_mem_req, a_if_rv); end
    endtask

    task automatic test_simultaneous();
        apply_reset();
        bus.if_req = 1'b1; bus.if_addr = 32'h300;
        bus.dm_req = 1'b1; bus.dm_we = 1'b1; bus.dm_addr = 32'h200; bus.dm_wdata = 32'hCAFE0001; bus.dm_be = 4'hF;
        step();
        n_cmp++; if (a_dm_gnt !== 1'b1 || a_if_gnt !== 1'b0) begin
            n_err++; $display("FAIL simul_first got=dm%b/if%b exp=dm1/if0", a_dm_gnt, a_if_gnt); end
        bus.mem_ack = 1'b1;
        step();
        n_cmp++; if (a_mem_we !== 1'b1 || a_mem_addr !== 32'h200 || a_mem_wdata !== 32'hCAFE0001 || a_mem_be !== 4'hF) begin
            n_err++; $display("FAIL simul_store got=%b/%h/%h/%h exp=1/200/cafe0001/f", a_mem_we, a_mem_addr, a_mem_wdata, a_mem_be); end
        n_cmp++; if (a_dm_rv !== 1'b1 || a_if_gnt !== 1'b1 || a_dm_gnt !== 1'b0) begin
            n_err++; $display("FAIL simul_handover got=rv%b/ifg%b/dmg%b exp=1/1/0", a_dm_rv, a_if_gnt, a_dm_gnt); end
        bus.dm_req = 1'b0; bus.mem_rdata = 32'h12345678;
        step();
        n_cmp++; if (a_mem_req !== 1'b1 || a_mem_addr !== 32'h300 || a_mem_we !== 1'b0 || a_mem_be !== 4'h0) begin
            n_err++; $display("FAIL simul_fetch got=%b/%h/%b/%h exp=1/300/0/0", a_mem_req, a_mem_addr, a_mem_we, a_mem_be); end
        n_cmp++; if (a_if_rv !== 1'b1 || a_if_rdata !== 32'h12345678) begin
            n_err++; $display("FAIL simul_fetch_data got=%b/%h exp=1/12345678", a_if_rv, a_if_rdata); end
        bus.if_req = 1'b0; bus.mem_ack = 1'b0;
        step();
    endtask

    // Fetch requests alongside each data request but backs off before the data completes,
    // so every data grant counts against fetch until the limit hands the port to fetch.
    task automatic test_starvation();
        apply_reset();
        for (int r = 0; r <= LIMIT; r++) begin
            bus.if_req = 1'b1; bus.if_addr = 32'h500 + 32'(r * 4);
            bus.dm_req = 1'b1; bus.dm_we = 1'b0; bus.dm_addr = 32'h600 + 32'(r * 4);
            bus.mem_ack = 1'b0;
            step();
            n_cmp++;
            if (r < LIMIT && (a_dm_gnt !== 1'b1 || a_if_gnt !== 1'b0)) begin
                n_err++; $display("FAIL starve_round%0d got=dm%b/if%b exp=dm1/if0", r, a_dm_gnt, a_if_gnt); end
            else if (r == LIMIT && (a_if_gnt !== 1'b1 || a_dm_gnt !== 1'b0)) begin
                n_err++; $display("FAIL starve_fetch_wins got=dm%b/if%b exp=dm0/if1", a_dm_gnt, a_if_gnt); end
            bus.if_req = 1'b0; bus.dm_req = 1'b0; bus.mem_ack = 1'b1;
            step();
            n_cmp++; if (int'(dut.starve_cnt) !== ((r < LIMIT) ? r + 1 : 0)) begin
                n_err++; $display("FAIL starve_cnt_round%0d got=%0d exp=%0d", r, dut.starve_cnt, (r < LIMIT) ? r + 1 : 0); end
        end
        bus.mem_ack = 1'b0;
        step();
    endtask

    task automatic test_latency();
        apply_reset();
        bus.dm_req = 1'b1; bus.dm_we = 1'b0; bus.dm_addr = 32'h400; bus.dm_be = 4'h3;
        step();
        bus.dm_addr = 32'hFFFF_0000;
        for (int w = 0; w < 7; w++) begin
            step();
            n_cmp++; if (a_mem_req !== 1'b1 || a_mem_addr !== 32'h400 || a_mem_be !== 4'h3 || a_stall_m !== 1'b1 || a_dm_rv !== 1'b0) begin
                n_err++; $display("FAIL latency_wait%0d got=%b/%h/%h/%b/%b exp=1/400/3/1/0", w, a_mem_req, a_mem_addr, a_mem_be, a_stall_m, a_dm_rv); end
        end
        bus.mem_ack = 1'b1; bus.mem_rdata = 32'hA5A5_5A5A;
        step();
        n_cmp++; if (a_dm_rv !== 1'b1 || a_dm_rdata !== 32'hA5A5_5A5A || a_stall_m !== 1'b0 || a_dm_gnt !== 1'b0) begin
            n_err++; $display("FAIL latency_done got=%b/%h/%b/%b exp=1/a5a55a5a/0/0", a_dm_rv, a_dm_rdata, a_stall_m, a_dm_gnt); end
        bus.mem_ack = 1'b0; bus.dm_req = 1'b0;
        step();
        n_cmp++; if (a_dm_rv !== 1'b0 || a_mem_req !== 1'b0) begin
            n_err++; $display("FAIL latency_single_pulse got=%b/%b exp=0/0", a_dm_rv, a_mem_req); end
    endtask

    task automatic test_stray_and_reset();
        apply_reset();
        bus.mem_ack = 1'b1;
        step();
        n_cmp++; if (a_if_rv !== 1'b0 || a_dm_rv !== 1'b0) begin
            n_err++; $display("FAIL stray_rvalid got=%b/%b exp=0/0", a_if_rv, a_dm_rv); end
        bus.mem_ack = 1'b0;
        step();
        n_cmp++; if (a_mem_req !== 1'b0 || dut.state_q !== ARB_IDLE) begin
            n_err++; $display("FAIL stray_state got=%b/%0d exp=0/0", a_mem_req, dut.state_q); end
        bus.if_req = 1'b1; bus.if_addr = 32'h700;
        bus.dm_req = 1'b1; bus.dm_addr = 32'h800;
        step();
        bus.if_req = 1'b0; bus.dm_req = 1'b0;
        step();
        #2;
        reset_n = 1'b0;
        #1;
        n_cmp++; if (bus.mem_req !== 1'b0 || dut.state_q !== ARB_IDLE || int'(dut.starve_cnt) !== 0) begin
            n_err++; $display("FAIL midreset got=%b/%0d/%0d exp=0/0/0", bus.mem_req, dut.state_q, dut.starve_cnt); end
        clear_inputs();
        model_reset();
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        bus.mem_ack = 1'b1; bus.mem_rdata = 32'h0BAD_0BAD;
        step();
        n_cmp++; if (a_dm_rv !== 1'b0 || a_if_rv !== 1'b0) begin
            n_err++; $display("FAIL late_ack got=%b/%b exp=0/0", a_dm_rv, a_if_rv); end
        bus.mem_ack = 1'b0;
        step();
        n_cmp++; if (a_mem_req !== 1'b0) begin n_err++; $display("FAIL late_ack_idle got=%b exp=0", a_mem_req); end
    endtask

    task automatic test_random();
        apply_reset();
        for (int c = 0; c < 600; c++) begin
            bus.mem_ack   = m_req ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 7) == 0);
            bus.mem_rdata = $urandom;
            step();
            n_cmp++; if (a_if_gnt !== e_if_gnt || a_dm_gnt !== e_dm_gnt) begin
                n_err++; $display("FAIL rnd_gnt c=%0d got=%b%b exp=%b%b", c, a_if_gnt, a_dm_gnt, e_if_gnt, e_dm_gnt); end
            n_cmp++; if (a_if_rv !== e_if_rv || a_dm_rv !== e_dm_rv) begin
                n_err++; $display("FAIL rnd_rvalid c=%0d got=%b%b exp=%b%b", c, a_if_rv, a_dm_rv, e_if_rv, e_dm_rv); end
            if (e_if_rv) begin
                n_cmp++; if (a_if_rdata !== e_rdata) begin n_err++; $display("FAIL rnd_if_rdata c=%0d got=%h exp=%h", c, a_if_rdata, e_rdata); end
            end
            if (e_dm_rv) begin
                n_cmp++; if (a_dm_rdata !== e_rdata) begin n_err++; $display("FAIL rnd_dm_rdata c=%0d got=%h exp=%h", c, a_dm_rdata, e_rdata); end
            end
            n_cmp++; if (a_stall_f !== e_stall_f || a_stall_m !== e_stall_m) begin
                n_err++; $display("FAIL rnd_stall c=%0d got=%b%b exp=%b%b", c, a_stall_f, a_stall_m, e_stall_f, e_stall_m); end
            n_cmp++; if (a_mem_req !== e_mem_req) begin n_err++; $display("FAIL rnd_mem_req c=%0d got=%b exp=%b", c, a_mem_req, e_mem_req); end
            if (e_mem_req) begin
                n_cmp++; if (a_mem_addr !== e_mem_addr || a_mem_we !== e_mem_we || a_mem_be !== e_mem_be) begin
                    n_err++; $display("FAIL rnd_mem_fields c=%0d got=%h/%b/%h exp=%h/%b/%h", c, a_mem_addr, a_mem_we, a_mem_be, e_mem_addr, e_mem_we, e_mem_be); end
                if (e_mem_we) begin
                    n_cmp++; if (a_mem_wdata !== e_mem_wdata) begin n_err++; $display("FAIL rnd_mem_wdata c=%0d got=%h exp=%h", c, a_mem_wdata, e_mem_wdata); end
                end
            end
            // Requesters keep their fields stable until granted, then may issue a new request.
            if (e_if_gnt || !bus.if_req) begin
                bus.if_req  = ($urandom_range(0, 1) == 1);
                bus.if_addr = {$urandom_range(0, 255), 2'b00};
            end
            if (e_dm_gnt || !bus.dm_req) begin
                bus.dm_req   = ($urandom_range(0, 1) == 1);
                bus.dm_we    = ($urandom_range(0, 1) == 1);
                bus.dm_addr  = {$urandom_range(0, 255), 2'b00};
                bus.dm_wdata = $urandom;
                bus.dm_be    = 4'($urandom_range(0, 15));
            end
        end
        clear_inputs();
        step();
    endtask

    initial begin
        clear_inputs();
        model_reset();
        test_reset();
        test_fetch_only();
        test_simultaneous();
        test_starvation();
        test_latency();
        test_stray_and_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
